uart_cmd_tx: RTL and testbench

Remote-side 16-bit command transmitter: accepts a 16-bit command word, serializes it as two back-to-back 8N1 UART frames (high byte first, then low byte) on `TX`, and flags completion. It is the block directly upstream of the robot's command receiver, which reassembles the two received bytes as `{first_byte, second_byte}` into its 16-bit `cmd`. It contains its own baud timer, shift register and byte-sequencing state machine.

---
 rtl/uart_cmd_tx.sv | 111 +++++++++++
 tb/tb_uart_cmd_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_tx.sv
// 16-bit command transmitter: sends cmd as two back-to-back 8N1 frames,
// high byte first, from a single baud timer and a 9-bit right shifter.
module uart_cmd_tx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        tx_busy,
  output logic        cmd_snt,
  output logic [1:0]  state_dbg,
  output logic [15:0] hold_dbg
);

  // Handshake: snd_cmd is a single-cycle request, taken only when the state
  // register reads IDLE at the rising edge; any other cycle drops it silently.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'd9;

  state_e      state;
  state_e      state_nxt;
  logic [15:0] cmd_hold;
  logic [8:0]  shifter;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;

  logic baud_tick;
  logic frame_done;
  logic accept;
  logic load_low;
  logic finish;

  assign baud_tick  = (state != IDLE) && (baud_cnt == BAUD_LAST);
  assign frame_done = baud_tick && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snd_cmd)    state_nxt = HIGH;
      HIGH:    if (frame_done) state_nxt = LOW;
      LOW:     if (frame_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    load_low = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    accept   = snd_cmd;
      HIGH:    load_low = frame_done;
      LOW:     finish   = frame_done;
      default: ;
    endcase
  end

  // The stop bit is the 1 shifted in at the MSB, so it lasts a full bit period
  // and the next load lands exactly on the following cycle with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_hold <= '0;
      shifter  <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_busy  <= 1'b0;
      cmd_snt  <= 1'b0;
    end else if (accept) begin
      cmd_hold <= cmd;
      shifter  <= {cmd[15:8], 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_busy  <= 1'b1;
      cmd_snt  <= 1'b0;
    end else if (baud_tick) begin
      baud_cnt <= '0;
      if (load_low) begin
        shifter <= {cmd_hold[7:0], 1'b0};
        bit_cnt <= '0;
      end else if (finish) begin
        shifter <= '1;
        bit_cnt <= '0;
        tx_busy <= 1'b0;
        cmd_snt <= 1'b1;
      end else begin
        shifter <= {1'b1, shifter[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (state != IDLE) begin
      baud_cnt <= baud_cnt + 12'd1;
    end
  end

  assign TX        = shifter[0];
  assign state_dbg = state;
  assign hold_dbg  = cmd_hold;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx: cycle-exact waveform checks at two divisors,
// a UART receiver model for loopback, and mid-frame reset.
module tb_uart_cmd_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd16, cmd4;
  logic        snd16, snd4;
  logic        tx16, tx4, busy16, busy4, snt16, snt4;
  logic [1:0]  st16, st4;
  logic [15:0] hold16, hold4;

  int n_cmp;
  int n_err;
  int snt_rises16;
  bit sel4;
  logic [15:0] exp_q[$];

  logic        tx_m, busy_m, snt_m;
  logic [1:0]  st_m;
  logic [15:0] hold_m;

  assign tx_m   = sel4 ? tx4   : tx16;
  assign busy_m = sel4 ? busy4 : busy16;
  assign snt_m  = sel4 ? snt4  : snt16;
  assign st_m   = sel4 ? st4   : st16;
  assign hold_m = sel4 ? hold4 : hold16;

  uart_cmd_tx #(.BAUD_DIV(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd16), .snd_cmd(snd16), .TX(tx16),
    .tx_busy(busy16), .cmd_snt(snt16), .state_dbg(st16), .hold_dbg(hold16)
  );

  uart_cmd_tx #(.BAUD_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd4), .snd_cmd(snd4), .TX(tx4),
    .tx_busy(busy4), .cmd_snt(snt4), .state_dbg(st4), .hold_dbg(hold4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic [15:0] c);
    if (sel4) begin
      snd4 = s;
      cmd4 = c;
    end else begin
      snd16 = s;
      cmd16 = c;
    end
  endtask

  task automatic request(input logic [15:0] w, input bit push);
    @(negedge clk);
    drive(1'b1, w);
    if (push && !sel4) exp_q.push_back(w);
  endtask

  // Called right after the accepting edge; n counts cycles after it.
  task automatic watch(input logic [19:0] frame, input logic [15:0] w,
                       input bit inject, input bit chain, input logic [15:0] nw);
    int b;
    logic exp_tx;
    b = sel4 ? 4 : 16;
    for (int n = 1; n <= 20 * b + 1; n++) begin
      @(negedge clk);
      exp_tx = (n <= 20 * b) ? frame[(n - 1) / b] : 1'b1;
      check_eq("tx_bit", 32'(tx_m), 32'(exp_tx));
      if (n == 1) begin
        check_eq("busy_rise", 32'(busy_m), 32'd1);
        check_eq("snt_fall", 32'(snt_m), 32'd0);
        check_eq("state_high", 32'(st_m), 32'd1);
        drive(1'b0, 16'($urandom));
      end
      if (n == 10 * b + 1) check_eq("state_low", 32'(st_m), 32'd2);
      if (n == 20 * b) begin
        check_eq("busy_last", 32'(busy_m), 32'd1);
        check_eq("snt_early", 32'(snt_m), 32'd0);
      end
      if (n == 20 * b + 1) begin
        check_eq("busy_end", 32'(busy_m), 32'd0);
        check_eq("snt_rise", 32'(snt_m), 32'd1);
        check_eq("state_idle", 32'(st_m), 32'd0);
        check_eq("cmd_hold", 32'(hold_m), 32'(w));
      end
      if (inject && n == 15 * b) drive(1'b1, 16'h1234);
      if (inject && n == 15 * b + 1) drive(1'b0, 16'($urandom));
      if (chain && n == 20 * b) begin
        drive(1'b1, nw);
        if (!sel4) exp_q.push_back(nw);
      end
    end
  endtask

  // scoreboard side: receiver model on the 16-divisor line
  initial begin : rx_model
    logic [7:0]  byt;
    logic [7:0]  hi_b;
    logic [15:0] got;
    bit          have_hi;
    byt = '0;
    hi_b = '0;
    have_hi = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx16 === 1'b0) begin
        repeat (7) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          byt[i] = tx16;
        end
        repeat (16) @(negedge clk);
        check_eq("rx_stop", 32'(tx16), 32'd1);
        if (!have_hi) begin
          hi_b = byt;
          have_hi = 1'b1;
        end else begin
          have_hi = 1'b0;
          got = {hi_b, byt};
          if (exp_q.size() == 0) check_eq("rx_pending", 32'(exp_q.size()), 32'd1);
          else check_eq("rx_word", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : snt_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (snt16 === 1'b1 && prev !== 1'b1) snt_rises16++;
      prev = snt16;
    end
  end

  initial begin : main
    int lows;
    n_cmp = 0;
    n_err = 0;
    snt_rises16 = 0;
    sel4 = 1'b0;
    cmd16 = '0;
    cmd4 = '0;
    snd16 = 1'b0;
    snd4 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx16), 32'd1);
    check_eq("rst_busy", 32'(busy16), 32'd0);
    check_eq("rst_snt", 32'(snt16), 32'd0);
    check_eq("rst_state", 32'(st16), 32'd0);
    check_eq("rst_tx4", 32'(tx4), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic send, then a request arriving mid low frame
    request(16'hA53C, 1'b1);
    watch(20'b1001111000_1101001010, 16'hA53C, 1'b0, 1'b0, 16'h0);
    request(16'hA53C, 1'b1);
    watch(20'b1001111000_1101001010, 16'hA53C, 1'b1, 1'b0, 16'h0);

    // loopback words; 0000 chains into FFFF across the LOW-to-IDLE boundary
    request(16'h0000, 1'b1);
    watch(20'b1000000000_1000000000, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    watch(20'b1111111110_1111111110, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    request(16'h8001, 1'b1);
    watch(20'b1000000010_1100000000, 16'h8001, 1'b0, 1'b0, 16'h0);
    check_eq("rx_drained", 32'(exp_q.size()), 32'd0);

    // minimum divisor
    sel4 = 1'b1;
    request(16'h5AC3, 1'b0);
    watch(20'b1110000110_1010110100, 16'h5AC3, 1'b0, 1'b0, 16'h0);
    sel4 = 1'b0;

    // reset in the middle of high-frame data bit d2 (a 0 for 8'hC3)
    request(16'hC3A5, 1'b0);
    for (int n = 1; n <= 57; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b0, 16'h0);
    end
    check_eq("pre_rst_tx", 32'(tx16), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_tx", 32'(tx16), 32'd1);
    check_eq("async_busy", 32'(busy16), 32'd0);
    check_eq("async_snt", 32'(snt16), 32'd0);
    check_eq("async_state", 32'(st16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx16 !== 1'b1) lows++;
      if (busy16 !== 1'b0) lows++;
    end
    check_eq("post_rst_quiet", 32'(lows), 32'd0);
    check_eq("snt_rises", 32'(snt_rises16), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
